// File: rtl/sram_bist_pkg.sv
// Shared types for the BIST-facing SRAM fault model: fault encodings, fault-table
// entry layout, FSM states and default geometry.
package sram_bist_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 4;
    localparam int NFLT_DEF     = 4;
    // Entry address field is sized for the widest supported array so the struct stays unparameterised
    localparam int FLT_ADDR_MAX = 16;

    typedef enum logic [1:0] {
        FLT_SA0 = 2'b00,
        FLT_SA1 = 2'b01,
        FLT_TFU = 2'b10,
        FLT_TFD = 2'b11
    } flt_type_e;

    typedef struct packed {
        logic                    vld;
        flt_type_e               ftype;
        logic [FLT_ADDR_MAX-1:0] addr;
        logic [1:0]              fbit;
    } flt_entry_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sram_state_e;

endpackage

// File: rtl/sram_fault_apply.sv
// Combinational fault rules: derives the word actually stored on a write and the
// word seen on read_d from the fault table, the access address and the cell contents.
module sram_fault_apply
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NFLT   = NFLT_DEF
) (
    input  flt_entry_t        flt_tbl_i [NFLT],
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic [DATA_W-1:0] new_i,
    output logic [DATA_W-1:0] wr_word_o,
    output logic [DATA_W-1:0] rd_word_o
);

    logic [DATA_W-1:0] mask;

    // Entries are applied in index order so the highest matching index has the last word
    always_comb begin
        wr_word_o = new_i;
        rd_word_o = stored_i;
        mask      = '0;
        for (int i = 0; i < NFLT; i++) begin
            mask = DATA_W'(1) << flt_tbl_i[i].fbit;
            if (flt_tbl_i[i].vld && (flt_tbl_i[i].addr == FLT_ADDR_MAX'(addr_i))) begin
                case (flt_tbl_i[i].ftype)
                    FLT_SA0: begin
                        wr_word_o = wr_word_o & ~mask;
                        rd_word_o = rd_word_o & ~mask;
                    end
                    FLT_SA1: begin
                        wr_word_o = wr_word_o | mask;
                        rd_word_o = rd_word_o | mask;
                    end
                    FLT_TFU: begin
                        if ((stored_i & mask) == '0) wr_word_o = wr_word_o & ~mask;
                    end
                    FLT_TFD: begin
                        if ((stored_i & mask) != '0) wr_word_o = wr_word_o | mask;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/sram_fault_model.sv
// SRAM responder for a BIST controller with post-reset clear and access counters.
// Define SRAM_FAULT_INJ_EN to compile in the programmable fault table.
module sram_fault_model
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NFLT   = NFLT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] dat_in,
    input  logic              w_en,
    output logic [DATA_W-1:0] read_d,
    output logic              init_busy,
    input  logic              flt_wr,
    input  logic [1:0]        flt_idx,
    input  logic              flt_vld,
    input  logic [1:0]        flt_type,
    input  logic [ADDR_W-1:0] flt_addr,
    input  logic [1:0]        flt_bit,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    sram_state_e       state_q;
    logic [ADDR_W-1:0] initAddr_q;
    logic [DATA_W-1:0] readData_q;
    logic [15:0]       wrCnt_q, wrCnt_d;
    logic [15:0]       rdCnt_q, rdCnt_d;

    logic [DATA_W-1:0] storedWord;
    logic [DATA_W-1:0] wrWord;
    logic [DATA_W-1:0] rdWord;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;

    assign storedWord = mem_q[addr_in];

`ifdef SRAM_FAULT_INJ_EN
    flt_entry_t fltTbl_q [NFLT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NFLT; i++) fltTbl_q[i] <= '0;
        end else if (flt_wr) begin
            for (int i = 0; i < NFLT; i++) begin
                if (int'(flt_idx) == i) begin
                    fltTbl_q[i].vld   <= flt_vld;
                    fltTbl_q[i].ftype <= flt_type_e'(flt_type);
                    fltTbl_q[i].addr  <= FLT_ADDR_MAX'(flt_addr);
                    fltTbl_q[i].fbit  <= flt_bit;
                end
            end
        end
    end

    sram_fault_apply #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NFLT   (NFLT)
    ) u_apply (
        .flt_tbl_i (fltTbl_q),
        .addr_i    (addr_in),
        .stored_i  (storedWord),
        .new_i     (dat_in),
        .wr_word_o (wrWord),
        .rd_word_o (rdWord)
    );
`else
    logic unusedFlt;

    assign wrWord    = dat_in;
    assign rdWord    = storedWord;
    assign unusedFlt = ^{flt_wr, flt_idx, flt_vld, flt_type, flt_addr, flt_bit};
`endif

    // INIT owns the write port; BIST accesses are ignored until the clear completes
    always_comb begin
        memWe   = 1'b0;
        memAddr = addr_in;
        memData = wrWord;
        if (state_q == ST_INIT) begin
            memWe   = 1'b1;
            memAddr = initAddr_q;
            memData = '0;
        end else if (w_en) begin
            memWe = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) mem_q[memAddr] <= memData;
    end

    always_comb begin
        wrCnt_d = (wrCnt_q == 16'hFFFF) ? wrCnt_q : wrCnt_q + 16'd1;
        rdCnt_d = (rdCnt_q == 16'hFFFF) ? rdCnt_q : rdCnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            initAddr_q <= '0;
            readData_q <= '0;
            wrCnt_q    <= '0;
            rdCnt_q    <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    initAddr_q <= initAddr_q + ADDR_W'(1);
                    if (initAddr_q == '1) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    // Read-first: a write also returns the pre-write word
                    readData_q <= rdWord;
                    if (w_en) wrCnt_q <= wrCnt_d;
                    else      rdCnt_q <= rdCnt_d;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign read_d    = readData_q;
    assign init_busy = (state_q == ST_INIT);
    assign wr_cnt    = wrCnt_q;
    assign rd_cnt    = rdCnt_q;

endmodule
